dm_cache_mem: RTL and testbench
===============================

DM_CACHE_MEM -- requirements
Module: dm_cache_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 256-bit blocks stored (power of two, 2..65536).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from request accept to response (integer, 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port mem_req_addr  input  32  byte address from the cache FSM; bits [4:0] ignored.
REQ-006 SHALL have port mem_req_data  input  256  write block from the cache FSM.
REQ-007 SHALL have port mem_req_rw  input  1  1 = write block, 0 = read block.
REQ-008 SHALL have port mem_req_valid  input  1  request present.
REQ-009 SHALL have port mem_data_rdata  output  256  read block returned to the cache FSM.
REQ-010 SHALL have port mem_data_ready  output  1  one-cycle completion pulse for the current request.
REQ-011 SHALL have port mem_busy  output  1  high while a request is in flight (BUSY or RESP).
REQ-012 SHALL have port rd_count  output  16  completed reads, saturating.
REQ-013 SHALL have port wr_count  output  16  completed writes, saturating.

Function
REQ-014 SHALL store DEPTH blocks of 256 bits, indexed by mem_req_addr[4+log2(DEPTH):5]; higher address bits ignored (aliasing wrap).
REQ-015 SHALL initialise every block to zero at time zero; reset SHALL NOT alter stored blocks.
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-017 IDLE: mem_req_valid=1 at a rising edge SHALL capture addr, data, rw and move to BUSY with the latency counter loaded with LATENCY-1.
REQ-018 IDLE with mem_req_valid=0 SHALL remain IDLE with no state change.
REQ-019 BUSY SHALL decrement the counter each edge and move to RESP on the edge where it reaches 1.
REQ-020 RESP SHALL last exactly one cycle with mem_data_ready=1, then return to IDLE.
REQ-021 mem_data_ready SHALL be high only in RESP, i.e. during exactly one cycle, sampled high at the LATENCY-th edge after the accept edge.
REQ-022 For a read, mem_data_rdata SHALL present the addressed block throughout the RESP cycle and hold it until the next read completes.
REQ-023 For a write, the captured block SHALL be committed on the edge leaving RESP; mem_data_rdata SHALL remain unchanged.
REQ-024 A read to a block written by an earlier completed request SHALL return the written data.
REQ-025 mem_req_* changes while BUSY or RESP SHALL be ignored; only captured values are used.
REQ-026 mem_req_valid still high in the first IDLE cycle after RESP SHALL be accepted as a new request; back-to-back requests are legal.
REQ-027 rd_count/wr_count SHALL increment on the edge leaving RESP for reads/writes respectively, saturating at 16'hFFFF.
REQ-028 mem_busy SHALL be 1 in BUSY and RESP, 0 in IDLE.

Reset
REQ-029 rst=0 SHALL immediately, without a clock, force IDLE, mem_data_ready=0, mem_busy=0, mem_data_rdata=0, rd_count=0, wr_count=0, latency counter=0.
REQ-030 Reset asserted while BUSY or RESP SHALL abort the request; an aborted write SHALL NOT be committed and SHALL NOT be counted.
REQ-031 After rst returns to 1, the first request SHALL be accepted on the first rising edge with mem_req_valid=1.

Verification
REQ-032 Read after reset: read addr 32'h0000_0040 -> ready pulse at accept edge +4, rdata=256'h0, rd_count=1.
REQ-033 Write then read: write block {8{32'hDEAD_BEEF}} to 32'h0000_0100, then read 32'h0000_0100 -> rdata={8{32'hDEAD_BEEF}}, wr_count=1, rd_count=1, rdata unchanged during the write RESP cycle.
REQ-034 Aliasing: with DEPTH=1024, write to 32'h0000_8020, read 32'h0000_0020 -> same block returned.
REQ-035 Input churn: change addr/rw/data every cycle while BUSY -> response reflects captured request only; exactly one ready pulse.
REQ-036 Reset mid-write: assert rst=0 two cycles after accepting a write to 32'h0000_0200, release, read 32'h0000_0200 -> old contents, wr_count=0, ready low during reset.
REQ-037 Back-to-back: valid held high over 3 reads with LATENCY=2 -> ready pulses exactly 3 cycles apart, rd_count=3.

Source files
------------

// File: rtl/dm_cache_mem.sv
// Block-wide backing memory for a direct-mapped cache. It serves one read or
// write of a 256-bit block at a time, with a fixed request-to-response latency.
module dm_cache_mem #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_req_addr,
  input  logic [255:0] mem_req_data,
  input  logic         mem_req_rw,
  input  logic         mem_req_valid,
  output logic [255:0] mem_data_rdata,
  output logic         mem_data_ready,
  output logic         mem_busy,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_cnt;
  logic [AW-1:0]  r_idx;
  logic [255:0]   r_wdata;
  logic           r_rw;
  logic [255:0]   r_rdata;
  logic [15:0]    r_rd_cnt;
  logic [15:0]    r_wr_cnt;

  // NOTE: the block store is never reset; it starts at zero and only writes change it.
  logic [255:0]   r_mem [DEPTH] = '{default: '0};

  // Byte offset and bits above the index are don't-care (address aliasing).
  logic w_unused_addr;
  assign w_unused_addr = ^{mem_req_addr[31:AW+5], mem_req_addr[4:0]};

  // NOTE: w_next gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (mem_req_valid) w_next = S_BUSY;
      S_BUSY:  if (r_cnt <= 8'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rw     <= 1'b0;
      r_rdata  <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (mem_req_valid) begin
            r_idx   <= mem_req_addr[AW+4:5];
            r_wdata <= mem_req_data;
            r_rw    <= mem_req_rw;
            r_cnt   <= LAT_LOAD;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 8'd1;
          // Read data is loaded as RESP is entered so it is stable for the whole cycle.
          if (w_next == S_RESP && !r_rw) r_rdata <= r_mem[r_idx];
        end
        S_RESP: begin
          if (r_rw) begin
            if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
          end else begin
            if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A reset during BUSY/RESP forces IDLE at once, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_rw) r_mem[r_idx] <= r_wdata;
  end

  assign mem_data_rdata = r_rdata;
  assign mem_data_ready = (r_state == S_RESP);
  assign mem_busy       = (r_state != S_IDLE);
  assign rd_count       = r_rd_cnt;
  assign wr_count       = r_wr_cnt;

endmodule

// File: tb/tb_dm_cache_mem.sv
// Directed bench for dm_cache_mem: a vector table of single transactions on a
// LATENCY=4 instance, plus churn, mid-write reset and back-to-back sequences.
module tb_dm_cache_mem;

  localparam logic [255:0] P_DB = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] P_1  = {8{32'h1234_5678}};
  localparam logic [255:0] P_2  = {8{32'hA5A5_0F0F}};
  localparam logic [255:0] P_3  = {8{32'hFFFF_0000}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         rw = 1'b0;
  logic         valid = 1'b0;
  logic         valid2 = 1'b0;
  logic [255:0] rdata, rdata2;
  logic         ready, ready2, busy, busy2;
  logic [15:0]  rdc, wrc, rdc2, wrc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_cache_mem #(.DEPTH(1024), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(addr), .mem_req_data(wdata), .mem_req_rw(rw), .mem_req_valid(valid),
    .mem_data_rdata(rdata), .mem_data_ready(ready), .mem_busy(busy),
    .rd_count(rdc), .wr_count(wrc)
  );

  dm_cache_mem #(.DEPTH(16), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .mem_req_addr(addr), .mem_req_data(wdata), .mem_req_rw(rw), .mem_req_valid(valid2),
    .mem_data_rdata(rdata2), .mem_data_ready(ready2), .mem_busy(busy2),
    .rd_count(rdc2), .wr_count(wrc2)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    logic         rw;
    logic [255:0] exp_rdata;
    logic [15:0]  exp_rd;
    logic [15:0]  exp_wr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on u_dut; checks latency, a single ready pulse and the RESP-cycle data.
  task automatic run_xact(input string tag, input logic [31:0] a, input logic [255:0] d,
                          input logic w, input logic [255:0] exp_rdata);
    int lat;
    int pulses;
    @(negedge clk);
    addr = a; wdata = d; rw = w; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          check({tag, " rdata"}, rdata, exp_rdata);
          check({tag, " busy_in_resp"}, 256'(busy), 256'(1));
        end
      end
    end
    check({tag, " latency"}, 256'(lat), 256'(4));
    check({tag, " pulses"}, 256'(pulses), 256'(1));
    check({tag, " busy_after"}, 256'(busy), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pos[3];
    int rhigh;

    vecs[0] = '{32'h0000_0040, 256'h0, 1'b0, 256'h0, 16'd1, 16'd0};
    vecs[1] = '{32'h0000_0100, P_DB,   1'b1, 256'h0, 16'd1, 16'd1};
    vecs[2] = '{32'h0000_0100, 256'h0, 1'b0, P_DB,   16'd2, 16'd1};
    vecs[3] = '{32'h0000_8020, P_1,    1'b1, P_DB,   16'd2, 16'd2};
    vecs[4] = '{32'h0000_0020, 256'h0, 1'b0, P_1,    16'd3, 16'd2};
    vecs[5] = '{32'h0000_011F, 256'h0, 1'b0, P_DB,   16'd4, 16'd2};
    vecs[6] = '{32'h0000_0200, P_2,    1'b1, P_DB,   16'd4, 16'd3};
    vecs[7] = '{32'h0000_0200, 256'h0, 1'b0, P_2,    16'd5, 16'd3};

    #1;
    check("reset ready", 256'(ready), 256'(0));
    check("reset busy", 256'(busy), 256'(0));
    check("reset rdata", rdata, 256'h0);
    check("reset rd_count", 256'(rdc), 256'(0));
    check("reset wr_count", 256'(wrc), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_xact($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].rw, vecs[i].exp_rdata);
      check($sformatf("vec%0d rd_count", i), 256'(rdc), 256'(vecs[i].exp_rd));
      check($sformatf("vec%0d wr_count", i), 256'(wrc), 256'(vecs[i].exp_wr));
      check($sformatf("vec%0d rdata_hold", i), rdata, vecs[i].exp_rdata);
    end

    // Inputs churn every cycle while the captured read of 0x100 is in flight.
    @(negedge clk);
    addr = 32'h0000_0100; rw = 1'b0; wdata = '0; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    n = 0;
    pos[0] = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready) begin
        if (n == 0) begin
          pos[0] = k;
          check("churn rdata", rdata, P_DB);
        end
        n++;
      end
      addr  = $urandom;
      wdata = {8{$urandom}};
      rw    = 1'($urandom_range(0, 1));
    end
    rw = 1'b0;
    check("churn latency", 256'(pos[0]), 256'(4));
    check("churn pulses", 256'(n), 256'(1));
    check("churn rd_count", 256'(rdc), 256'(6));
    check("churn wr_count", 256'(wrc), 256'(3));

    // Reset two cycles into a write of 0x200; the old block must survive.
    @(negedge clk);
    addr = 32'h0000_0200; wdata = P_3; rw = 1'b1; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst busy_before", 256'(busy), 256'(1));
    rst = 1'b0;
    #1;
    check("midrst ready", 256'(ready), 256'(0));
    check("midrst busy", 256'(busy), 256'(0));
    check("midrst rdata", rdata, 256'h0);
    check("midrst rd_count", 256'(rdc), 256'(0));
    check("midrst wr_count", 256'(wrc), 256'(0));
    rhigh = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready) rhigh++;
    end
    check("midrst ready_during_reset", 256'(rhigh), 256'(0));
    rw = 1'b0;
    rst = 1'b1;
    run_xact("midrst_rd", 32'h0000_0200, 256'h0, 1'b0, P_2);
    check("midrst_rd wr_count", 256'(wrc), 256'(0));
    check("midrst_rd rd_count", 256'(rdc), 256'(1));

    // Back-to-back reads on the LATENCY=2 instance with valid held high.
    @(negedge clk);
    addr = 32'h0000_0040; rw = 1'b0; valid2 = 1'b1;
    @(posedge clk);
    n = 0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready2) begin
        if (n < 3) pos[n] = k;
        n++;
        if (n == 3) valid2 = 1'b0;
      end
    end
    valid2 = 1'b0;
    check("b2b pulses", 256'(n), 256'(3));
    check("b2b first", 256'(pos[0]), 256'(2));
    check("b2b gap1", 256'(pos[1] - pos[0]), 256'(3));
    check("b2b gap2", 256'(pos[2] - pos[1]), 256'(3));
    check("b2b rd_count", 256'(rdc2), 256'(3));
    check("b2b wr_count", 256'(wrc2), 256'(0));
    check("b2b rdata", rdata2, 256'h0);
    check("b2b busy_after", 256'(busy2), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
